// File: rtl/or_edge_counter.sv
// Rising-edge event counter for the asynchronous OR-gate output: synchroniser,
// edge detector, saturating counter with threshold pulse, and a retriggerable pulse stretcher.
module or_edge_counter #(
    parameter int CNT_W       = 8,
    parameter int STRETCH     = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             o_in,
    input  logic             en,
    input  logic             clr,
    input  logic [CNT_W-1:0] thresh,
    output logic             level,
    output logic             rise,
    output logic [CNT_W-1:0] count,
    output logic             sat,
    output logic             hit,
    output logic             stretch_o
);

    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
    localparam logic [7:0]       SCNT_LOAD = 8'(STRETCH - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   r_rise;
    logic [CNT_W-1:0]       r_count;
    logic                   r_sat;
    logic                   r_hit;
    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [7:0]             r_scnt;
    logic [7:0]             w_scnt_nxt;
    logic                   w_level;
    logic                   w_at_max;
    logic                   w_inc;
    logic [CNT_W-1:0]       w_count_nxt;

    assign w_level = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], o_in};
            r_prev <= w_level;
            r_rise <= w_level & ~r_prev;
        end
    end

    // Clear wins over a coincident rise; a saturated counter neither wraps nor re-hits.
    assign w_at_max    = (r_count == CNT_MAX);
    assign w_inc       = r_rise & en & ~w_at_max;
    assign w_count_nxt = r_count + CNT_ONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_sat   <= 1'b0;
            r_hit   <= 1'b0;
        end else if (clr) begin
            r_count <= '0;
            r_sat   <= 1'b0;
            r_hit   <= 1'b0;
        end else begin
            r_hit <= 1'b0;
            if (w_inc) begin
                r_count <= w_count_nxt;
                r_hit   <= (thresh != CNT_ZERO) && (w_count_nxt == thresh);
                if (w_count_nxt == CNT_MAX) begin
                    r_sat <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_scnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_scnt  <= w_scnt_nxt;
        end
    end

    // HOLD lasts scnt+1 cycles after the last load, giving STRETCH high cycles per isolated rise.
    always_comb begin
        w_state_nxt = r_state;
        w_scnt_nxt  = r_scnt;
        case (r_state)
            S_IDLE: begin
                if (r_rise) begin
                    w_state_nxt = S_HOLD;
                    w_scnt_nxt  = SCNT_LOAD;
                end
            end
            S_HOLD: begin
                if (r_rise) begin
                    w_scnt_nxt = SCNT_LOAD;
                end else if (r_scnt != 8'd0) begin
                    w_scnt_nxt = r_scnt - 8'd1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_scnt_nxt  = '0;
            end
        endcase
    end

    assign level     = w_level;
    assign rise      = r_rise;
    assign count     = r_count;
    assign sat       = r_sat;
    assign hit       = r_hit;
    assign stretch_o = (r_state == S_HOLD);

endmodule

// File: tb/tb_or_edge_counter.sv
// Bench for or_edge_counter: an 8-bit and a 2-bit counter instance share the same stimulus
// and are compared every cycle against an edge-indexed behavioural model.
module tb_or_edge_counter;

    localparam int S  = 2;
    localparam int ST = 4;

    logic       clk;
    logic       rst_n = 1'b0;
    logic       o_in  = 1'b0;
    logic       en    = 1'b1;
    logic       clr   = 1'b0;
    logic [7:0] thresh8 = 8'd3;
    logic [1:0] thresh2 = 2'd3;

    logic       level8, rise8, sat8, hit8, stretch8;
    logic [7:0] count8;
    logic       level2, rise2, sat2, hit2, stretch2;
    logic [1:0] count2;

    or_edge_counter #(.CNT_W(8), .STRETCH(ST), .SYNC_STAGES(S)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .o_in(o_in), .en(en), .clr(clr), .thresh(thresh8),
        .level(level8), .rise(rise8), .count(count8), .sat(sat8), .hit(hit8),
        .stretch_o(stretch8)
    );

    or_edge_counter #(.CNT_W(2), .STRETCH(ST), .SYNC_STAGES(S)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .o_in(o_in), .en(en), .clr(clr), .thresh(thresh2),
        .level(level2), .rise(rise2), .count(count2), .sat(sat2), .hit(hit2),
        .stretch_o(stretch2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Model: n counts clock edges since reset release; samp[n] is o_in seen at edge n.
    int n = 0;
    bit samp [0:4095];
    bit lv   [0:4095];
    bit rs   [0:4095];
    int m_cnt8 = 0, m_cnt2 = 0;
    bit m_sat8 = 0, m_sat2 = 0, m_hit8 = 0, m_hit2 = 0;
    bit m_level = 0, m_rise = 0, m_st = 0;

    function automatic bit lvl_at(input int k);
        return (k >= 1) ? lv[k] : 1'b0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n = 0;
            m_cnt8 = 0; m_cnt2 = 0;
            m_sat8 = 0; m_sat2 = 0; m_hit8 = 0; m_hit2 = 0;
            m_level = 0; m_rise = 0; m_st = 0;
        end else if (n < 4000) begin
            n++;
            samp[n] = o_in;
            lv[n]   = (n - S + 1 >= 1) ? samp[n-S+1] : 1'b0;
            rs[n]   = lvl_at(n-1) && !lvl_at(n-2);
            m_level = lv[n];
            m_rise  = rs[n];
            m_st    = 0;
            for (int k = n - ST; k <= n - 1; k++)
                if (k >= 1 && rs[k]) m_st = 1;
            if (clr) begin
                m_cnt8 = 0; m_sat8 = 0; m_hit8 = 0;
                m_cnt2 = 0; m_sat2 = 0; m_hit2 = 0;
            end else if (n >= 2 && rs[n-1] && en) begin
                m_hit8 = 0;
                if (m_cnt8 < 255) begin
                    m_cnt8++;
                    m_hit8 = (thresh8 != 0) && (m_cnt8 == int'(thresh8));
                    if (m_cnt8 == 255) m_sat8 = 1;
                end
                m_hit2 = 0;
                if (m_cnt2 < 3) begin
                    m_cnt2++;
                    m_hit2 = (thresh2 != 0) && (m_cnt2 == int'(thresh2));
                    if (m_cnt2 == 3) m_sat2 = 1;
                end
            end else begin
                m_hit8 = 0;
                m_hit2 = 0;
            end
        end
    end

    int t_rise = 0, t_hit8 = 0, t_st = 0, t_fall = 0;
    bit prev_st = 0;

    always @(negedge clk) begin
        chk("level8", level8, m_level);
        chk("rise8", rise8, m_rise);
        chk("count8", count8, m_cnt8);
        chk("sat8", sat8, m_sat8);
        chk("hit8", hit8, m_hit8);
        chk("stretch8", stretch8, m_st);
        chk("level2", level2, m_level);
        chk("rise2", rise2, m_rise);
        chk("count2", count2, m_cnt2);
        chk("sat2", sat2, m_sat2);
        chk("hit2", hit2, m_hit2);
        chk("stretch2", stretch2, m_st);
        t_rise += int'(rise8);
        t_hit8 += int'(hit8);
        t_st   += int'(stretch8);
        t_fall += int'(prev_st && !stretch8);
        prev_st = stretch8;
    end

    int s_rise, s_hit8, s_st, s_fall;
    task automatic snap;
        s_rise = t_rise; s_hit8 = t_hit8; s_st = t_st; s_fall = t_fall;
    endtask

    task automatic cyc(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic pulse(input int hi, input int lo);
        o_in = 1'b1; cyc(hi);
        o_in = 1'b0; cyc(lo);
    endtask

    task automatic do_clr;
        clr = 1'b1; cyc(1); clr = 1'b0;
    endtask

    int sat_cnt_exp [5] = '{1, 2, 3, 3, 3};

    initial begin
        // Reset held while o_in toggles
        repeat (3) begin
            @(negedge clk);
            o_in = ~o_in;
        end
        #1;
        chk("rst_level", level8, 0);
        chk("rst_rise", rise8, 0);
        chk("rst_count", count8, 0);
        chk("rst_sat", sat8, 0);
        chk("rst_hit", hit8, 0);
        chk("rst_stretch", stretch8, 0);
        chk("rst_count2", count2, 0);
        o_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc(2);

        // Basic counting, thresh=3
        #1 snap;
        for (int i = 1; i <= 3; i++) begin
            pulse(5, 5);
            #1 chk("basic_count", count8, i);
        end
        chk("basic_rises", t_rise - s_rise, 3);
        chk("basic_hits", t_hit8 - s_hit8, 1);
        chk("basic_stretch_cycles", t_st - s_st, 12);
        chk("basic_stretch_falls", t_fall - s_fall, 3);

        // Enable gating
        do_clr;
        en = 1'b0;
        #1 snap;
        pulse(5, 5);
        pulse(5, 5);
        #1;
        chk("gate_count", count8, 0);
        chk("gate_rises", t_rise - s_rise, 2);
        chk("gate_stretch_cycles", t_st - s_st, 8);
        en = 1'b1;
        pulse(5, 5);
        #1 chk("gate_count_en", count8, 1);

        // Threshold moved onto the current count does not pulse
        thresh8 = 8'd1;
        snap;
        cyc(4);
        #1 chk("thresh_move_hits", t_hit8 - s_hit8, 0);
        thresh8 = 8'd3;

        // Saturation on the 2-bit instance
        thresh2 = 2'd2;
        do_clr;
        for (int i = 0; i < 5; i++) begin
            pulse(5, 5);
            #1;
            chk("sat_count2", count2, sat_cnt_exp[i]);
            chk("sat_flag2", sat2, (i >= 2) ? 1 : 0);
        end
        do_clr;
        #1;
        chk("clr_count2", count2, 0);
        chk("clr_sat2", sat2, 0);

        // Clear coincident with a rise drops that rise
        o_in = 1'b1;
        cyc(3);
        #1 chk("coinc_rise_present", rise8, 1);
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
        o_in = 1'b0;
        cyc(5);
        #1;
        chk("coinc_count8", count8, 0);
        chk("coinc_count2", count2, 0);

        // Retrigger: rises every 3 cycles keep stretch_o high
        snap;
        for (int i = 0; i < 5; i++) pulse(1, 2);
        cyc(10);
        #1;
        chk("retrig_count", count8, 5);
        chk("retrig_rises", t_rise - s_rise, 5);
        chk("retrig_stretch_cycles", t_st - s_st, 16);
        chk("retrig_stretch_falls", t_fall - s_fall, 1);

        // Narrow pulse between edges is not seen
        snap;
        @(negedge clk);
        #1 o_in = 1'b1;
        #3 o_in = 1'b0;
        cyc(6);
        #1;
        chk("narrow_rises", t_rise - s_rise, 0);
        chk("narrow_count", count8, 5);

        // Long high gives one event
        snap;
        o_in = 1'b1;
        cyc(20);
        o_in = 1'b0;
        cyc(6);
        #1;
        chk("long_rises", t_rise - s_rise, 1);
        chk("long_count", count8, 6);

        // Asynchronous reset mid-stretch
        do_clr;
        for (int i = 0; i < 4; i++) pulse(5, 5);
        #1 o_in = 1'b1;
        cyc(4);
        #1;
        chk("pre_rst_count", count8, 5);
        chk("pre_rst_stretch", stretch8, 1);
        chk("pre_rst_level", level8, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_count", count8, 0);
        chk("async_rst_stretch", stretch8, 0);
        chk("async_rst_level", level8, 0);
        chk("async_rst_count2", count2, 0);
        o_in = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(3);
        #1 chk("post_rst_count", count8, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
